// File: rtl/butterfly_pkg.sv
// Shared definitions for the radix-2 butterfly stages (DIT and DIF).
// Holds the control state encoding and fixed-point helpers.
package butterfly_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF = 32;
  localparam int D_DEF = 16;

  // Fixed-point 1.0 for a word with 'frac' fractional bits.
  function automatic logic [63:0] fx_one(input int frac);
    return 64'(1) << frac;
  endfunction

endpackage

// File: rtl/butterfly_dif_cmul.sv
// Iterative signed complex multiplier: four shift-add real products share the
// multiplier bits of (yr, yi); fixed n-cycle latency from the start pulse.
module butterfly_dif_cmul
  import butterfly_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int d = D_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic signed [n-1:0] i_xr,
  input  logic signed [n-1:0] i_xc,
  input  logic signed [n-1:0] i_yr,
  input  logic signed [n-1:0] i_yi,
  output logic                o_done,
  output logic signed [n-1:0] o_dr,
  output logic signed [n-1:0] o_dc
);

  localparam int CW = $clog2(n);

  logic signed [2*n-1:0] r_mr, r_mc;
  logic signed [2*n-1:0] r_prr, r_pci, r_pri, r_pcr;
  logic        [n-1:0]   r_yr, r_yi;
  logic        [CW-1:0]  r_cnt;
  logic                  r_busy;
  logic                  w_last;
  logic signed [2*n-1:0] w_prr, w_pci, w_pri, w_pcr;

  // Partial product; the multiplier MSB carries weight -2^(n-1).
  function automatic logic signed [2*n-1:0] pp(input logic signed [2*n-1:0] m,
                                               input logic b, input logic neg);
    return b ? (neg ? -m : m) : '0;
  endfunction

  // Fixed-point rescale: floor(p / 2^d), wrapped to n bits.
  function automatic logic signed [n-1:0] trunc_fx(input logic signed [2*n-1:0] p);
    return p[n+d-1:d];
  endfunction

  assign w_last = (r_cnt == CW'(n-1));
  assign w_prr  = r_prr + pp(r_mr, r_yr[0], w_last);
  assign w_pci  = r_pci + pp(r_mc, r_yi[0], w_last);
  assign w_pri  = r_pri + pp(r_mr, r_yi[0], w_last);
  assign w_pcr  = r_pcr + pp(r_mc, r_yr[0], w_last);

  // Final step is folded in combinationally so the result lands on the n-th edge.
  assign o_done = r_busy & w_last;
  assign o_dr   = trunc_fx(w_prr) - trunc_fx(w_pci);
  assign o_dc   = trunc_fx(w_pri) + trunc_fx(w_pcr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mr   <= '0;
      r_mc   <= '0;
      r_prr  <= '0;
      r_pci  <= '0;
      r_pri  <= '0;
      r_pcr  <= '0;
      r_yr   <= '0;
      r_yi   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_mr   <= {{n{i_xr[n-1]}}, i_xr};
      r_mc   <= {{n{i_xc[n-1]}}, i_xc};
      r_yr   <= i_yr;
      r_yi   <= i_yi;
      r_prr  <= '0;
      r_pci  <= '0;
      r_pri  <= '0;
      r_pcr  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_prr  <= w_prr;
      r_pci  <= w_pci;
      r_pri  <= w_pri;
      r_pcr  <= w_pcr;
      r_mr   <= r_mr <<< 1;
      r_mc   <= r_mc <<< 1;
      r_yr   <= r_yr >> 1;
      r_yi   <= r_yi >> 1;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/butterfly_dif.sv
// Radix-2 decimation-in-frequency butterfly: c = a + b, d = (a - b) * w,
// with optional conj(w); one transaction in flight, val/rdy on both sides.
module butterfly_dif
  import butterfly_pkg::*;
#(
  parameter int n    = N_DEF,
  parameter int d    = D_DEF,
  parameter int mult = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                recv_val,
  output logic                recv_rdy,
  input  logic signed [n-1:0] ar,
  input  logic signed [n-1:0] ac,
  input  logic signed [n-1:0] br,
  input  logic signed [n-1:0] bc,
  input  logic signed [n-1:0] wr,
  input  logic signed [n-1:0] wc,
  input  logic                conj,
  output logic                send_val,
  input  logic                send_rdy,
  output logic signed [n-1:0] cr,
  output logic signed [n-1:0] cc,
  output logic signed [n-1:0] dr,
  output logic signed [n-1:0] dc
);

  state_t              r_state;
  logic                w_acc;
  logic                w_done;
  logic signed [n-1:0] w_sr, w_sc, w_wi, w_mdr, w_mdc;

  assign w_acc = recv_val & recv_rdy;
  assign w_sr  = ar - br;
  assign w_sc  = ac - bc;
  assign w_wi  = conj ? -wc : wc;

  generate
    if (mult != 0) begin : g_mul
      butterfly_dif_cmul #(.n(n), .d(d)) u_cmul (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_acc),
        .i_xr    (w_sr),
        .i_xc    (w_sc),
        .i_yr    (wr),
        .i_yi    (w_wi),
        .o_done  (w_done),
        .o_dr    (w_mdr),
        .o_dc    (w_mdc)
      );
    end else begin : g_nomul
      assign w_done = 1'b0;
      assign w_mdr  = '0;
      assign w_mdc  = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      recv_rdy <= 1'b1;
      send_val <= 1'b0;
      cr       <= '0;
      cc       <= '0;
      dr       <= '0;
      dc       <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          cr       <= ar + br;
          cc       <= ac + bc;
          recv_rdy <= 1'b0;
          if (mult == 0) begin
            dr       <= w_sr;
            dc       <= w_sc;
            send_val <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_state  <= MUL;
          end
        end
        MUL: if (w_done) begin
          dr       <= w_mdr;
          dc       <= w_mdc;
          send_val <= 1'b1;
          r_state  <= DONE;
        end
        // Results are held until downstream takes them; no same-edge re-accept.
        DONE: if (send_rdy) begin
          send_val <= 1'b0;
          recv_rdy <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
